// File: rtl/ulbf_data_rd_stream.sv
// ulbf_data_rd_stream: reads blocks of words from RAM port B and streams them out
// on AXI4-Stream through a small skid FIFO. One block is cfg_size words from cfg_base,
// repeated cfg_iter times. Optional macro ULBF_DATA_RD_LOOP_EN enables endless
// block repetition through cfg_loop.
module ulbf_data_rd_stream #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [CNT_W-1:0]  cfg_size,
    input  logic [CNT_W-1:0]  cfg_iter,
    input  logic              cfg_loop,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              sts_busy,
    output logic              sts_done,
    output logic [31:0]       sts_words
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_size;
    logic [CNT_W-1:0]    r_iter;
    logic [CNT_W-1:0]    r_idx;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_vld;
    logic                r_rd_last;
    logic                r_done;
    logic [31:0]         r_words;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_last_mem;
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [PW:0]         r_cnt;

    logic                w_loop;
    logic [PW+1:0]       w_occ;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_blk_end;
    logic                w_start;
    logic [PW:0]         w_cnt_nxt;

`ifdef ULBF_DATA_RD_LOOP_EN
    logic                r_loop;
    assign w_loop = r_loop;
`else
    logic                w_unused_loop;
    assign w_unused_loop = cfg_loop;
    assign w_loop        = 1'b0;
`endif

    // Reads are only issued while the FIFO can absorb every outstanding word,
    // so the FIFO cannot overflow whatever tready does.
    assign w_occ     = {1'b0, r_cnt} + {{(PW+1){1'b0}}, r_rd_vld};
    assign w_issue   = (r_state == S_RUN) && (w_occ < (PW+2)'(FIFO_DEPTH));
    assign w_push    = r_rd_vld;
    assign w_pop     = (r_cnt != '0) && m_axis_tready;
    assign w_blk_end = (r_idx == r_size - 1'b1);
    assign w_start   = (r_state == S_IDLE) && cfg_start && (cfg_size != '0) && !cfg_stop;
    assign w_cnt_nxt = r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};

    assign enb           = w_issue;
    assign addrb         = r_rd_addr;
    assign m_axis_tvalid = (r_cnt != '0);
    assign m_axis_tdata  = r_mem[r_rptr];
    assign m_axis_tlast  = r_last_mem[r_rptr] && m_axis_tvalid;
    assign sts_busy      = (r_state != S_IDLE);
    assign sts_done      = r_done;
    assign sts_words     = r_words;

    // Control FSM: latch config, walk addresses, count iterations, detect completion.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_size    <= '0;
            r_iter    <= '0;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_done    <= 1'b0;
`ifdef ULBF_DATA_RD_LOOP_EN
            r_loop    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (cfg_stop) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (w_start) begin
                        r_state   <= S_RUN;
                        r_base    <= cfg_base;
                        r_size    <= cfg_size;
                        r_iter    <= (cfg_iter == '0) ? CNT_W'(1) : cfg_iter;
                        r_idx     <= '0;
                        r_rd_addr <= cfg_base;
`ifdef ULBF_DATA_RD_LOOP_EN
                        r_loop    <= cfg_loop;
`endif
                    end
                    S_RUN: if (w_issue) begin
                        if (w_blk_end) begin
                            r_idx     <= '0;
                            r_rd_addr <= r_base;
                            if (!w_loop) begin
                                if (r_iter == CNT_W'(1)) r_state <= S_DRAIN;
                                else                     r_iter  <= r_iter - 1'b1;
                            end
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                    // Leave on the edge that empties the FIFO so done follows the tlast beat directly.
                    S_DRAIN: if (!r_rd_vld && (w_cnt_nxt == '0)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Read-in-flight tracker; a stop discards whatever read is outstanding.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld  <= w_issue && !cfg_stop;
            r_rd_last <= w_blk_end;
        end
    end

    // Output skid FIFO holding data plus its tlast tag; flushed on stop.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_last_mem <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
        end else if (cfg_stop) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]      <= doutb;
                r_last_mem[r_wptr] <= r_rd_last;
                r_wptr             <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Accepted-beat counter, cleared by an accepted start.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)  r_words <= '0;
        else if (w_start) r_words <= '0;
        else if (w_pop)   r_words <= r_words + 32'd1;
    end

endmodule

// File: tb/tb_ulbf_data_rd_stream.sv
// Directed bench for ulbf_data_rd_stream: table of block runs plus hand sequences
// for stop, ignored starts and asynchronous reset.
module tb_ulbf_data_rd_stream;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, cfg_loop = 1'b0;
    logic [15:0] cfg_base = '0, cfg_size = '0, cfg_iter = '0;
    logic [15:0] addrb;
    logic        enb;
    logic [63:0] doutb = '0;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
    logic        sts_busy, sts_done;
    logic [31:0] sts_words;

    ulbf_data_rd_stream dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_iter(cfg_iter), .cfg_loop(cfg_loop),
        .addrb(addrb), .enb(enb), .doutb(doutb), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .sts_busy(sts_busy), .sts_done(sts_done), .sts_words(sts_words)
    );

    always #5 ap_clk = ~ap_clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int tready_mode = 0;      // 0 always, 1 random, 2 never, 3 until budget
    int budget = 0;
    logic [64:0] beats[$];
    logic [15:0] addrs[$];
    int done_cnt = 0, done_cyc = -1, last_cyc = -1;
    logic prev_stall = 1'b0, prev_stop = 1'b0;
    logic [63:0] prev_data = '0;
    logic prev_last = 1'b0;

    function automatic logic [63:0] ram_word(input logic [15:0] a);
        return {16'hD47A, a, ~a, a ^ 16'h5A5A};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // RAM port B model: one-cycle read latency.
    always @(posedge ap_clk) if (enb) doutb <= ram_word(addrb);

    always @(posedge ap_clk) cyc <= cyc + 1;

    always @(posedge ap_clk) begin
        #1;
        case (tready_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            3: m_axis_tready = (beats.size() < budget);
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: reads issued, beats accepted, done pulses, stall stability.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !prev_stop) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", m_axis_tdata, prev_data);
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (enb) addrs.push_back(addrb);
            if (m_axis_tvalid && m_axis_tready) begin
                beats.push_back({m_axis_tlast, m_axis_tdata});
                if (m_axis_tlast) last_cyc = cyc;
            end
            if (sts_done) begin done_cnt++; done_cyc = cyc; end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_stop  = cfg_stop;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic clear_log();
        beats.delete(); addrs.delete();
        done_cnt = 0; done_cyc = -1; last_cyc = -1;
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] size;
        logic [15:0] iter;
        int          mode;
        int          exp_beats;
        int          exp_lasts;
        logic [15:0] exp_last_addr;
    } vec_t;

    task automatic run_vec(input vec_t v, input int vi);
        int lasts;
        logic [15:0] a;
        string s;
        clear_log();
        tready_mode = v.mode;
        cfg_base = v.base; cfg_size = v.size; cfg_iter = v.iter; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk($sformatf("v%0d_tvalid_early", vi), 64'(m_axis_tvalid), 64'd0);
        @(negedge ap_clk);
        chk($sformatf("v%0d_first_beat_lat", vi), 64'(m_axis_tvalid), 64'd1);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge ap_clk);
        tick(3);
        chk($sformatf("v%0d_done_cnt", vi), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d_done_after_tlast", vi), 64'(done_cyc), 64'(last_cyc + 1));
        chk($sformatf("v%0d_beats", vi), 64'(beats.size()), 64'(v.exp_beats));
        chk($sformatf("v%0d_reads", vi), 64'(addrs.size()), 64'(v.exp_beats));
        chk($sformatf("v%0d_words", vi), 64'(sts_words), 64'(v.exp_beats));
        chk($sformatf("v%0d_busy", vi), 64'(sts_busy), 64'd0);
        if (addrs.size() > 0)
            chk($sformatf("v%0d_last_addr", vi), 64'(addrs[addrs.size()-1]), 64'(v.exp_last_addr));
        lasts = 0;
        for (int i = 0; i < beats.size(); i++) begin
            a = v.base + 16'(i % int'(v.size));
            s = $sformatf("v%0d_beat%0d", vi, i);
            chk({s, "_data"}, beats[i][63:0], ram_word(a));
            chk({s, "_last"}, 64'(beats[i][64]), 64'((i % int'(v.size)) == int'(v.size) - 1));
            if (i < addrs.size()) chk({s, "_addr"}, 64'(addrs[i]), 64'(a));
            if (beats[i][64]) lasts++;
        end
        chk($sformatf("v%0d_lasts", vi), 64'(lasts), 64'(v.exp_lasts));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h0010, 16'd4, 16'd1, 0,  4, 1, 16'h0013};
        vecs[1] = '{16'h0100, 16'd8, 16'd3, 1, 24, 3, 16'h0107};
        vecs[2] = '{16'hFFFE, 16'd4, 16'd1, 0,  4, 1, 16'h0001};
        vecs[3] = '{16'h0020, 16'd1, 16'd0, 0,  1, 1, 16'h0020};
        vecs[4] = '{16'h0200, 16'd3, 16'd2, 1,  6, 2, 16'h0202};
        vecs[5] = '{16'hFFFF, 16'd2, 16'd2, 0,  4, 2, 16'h0000};

        // Reset state
        tick(3);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_enb", 64'(enb), 64'd0);
        chk("rst_addrb", 64'(addrb), 64'd0);
        chk("rst_busy", 64'(sts_busy), 64'd0);
        chk("rst_done", 64'(sts_done), 64'd0);
        chk("rst_words", 64'(sts_words), 64'd0);
        ap_rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Stop with tready low: FIFO fills, stop flushes, no done
        clear_log();
        tready_mode = 2;
        cfg_base = 16'h0400; cfg_size = 16'd16; cfg_iter = 16'd1; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tick(19);
        chk("stop_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("stop_pre_busy", 64'(sts_busy), 64'd1);
        chk("stop_reads_bounded", 64'(addrs.size() <= 4), 64'd1);
        chk("stop_reads_issued", 64'(addrs.size() > 0), 64'd1);
        cfg_stop = 1'b1;
        tick(1);
        cfg_stop = 1'b0;
        chk("stop_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("stop_busy", 64'(sts_busy), 64'd0);
        tick(1);
        chk("stop_enb", 64'(enb), 64'd0);
        tick(8);
        chk("stop_reads_total", 64'(addrs.size() <= 4), 64'd1);
        chk("stop_no_done", 64'(done_cnt), 64'd0);
        chk("stop_words", 64'(sts_words), 64'd0);
        chk("stop_no_beats", 64'(beats.size()), 64'd0);

        // size=0 start is ignored
        clear_log();
        tready_mode = 0;
        cfg_size = 16'd0; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tick(6);
        chk("size0_busy", 64'(sts_busy), 64'd0);
        chk("size0_reads", 64'(addrs.size()), 64'd0);

        // start and stop together from IDLE: stop wins
        cfg_size = 16'd4; cfg_start = 1'b1; cfg_stop = 1'b1;
        tick(1);
        cfg_start = 1'b0; cfg_stop = 1'b0;
        tick(4);
        chk("startstop_busy", 64'(sts_busy), 64'd0);
        chk("startstop_reads", 64'(addrs.size()), 64'd0);

        // start while busy and cfg changes mid-run are ignored
        clear_log();
        tready_mode = 2;
        cfg_base = 16'h0080; cfg_size = 16'd8; cfg_iter = 16'd1; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tick(4);
        cfg_base = 16'h0300; cfg_size = 16'd2; cfg_iter = 16'd5; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tready_mode = 0;
        for (int c = 0; c < 500 && done_cnt == 0; c++) @(negedge ap_clk);
        tick(2);
        chk("restart_beats", 64'(beats.size()), 64'd8);
        chk("restart_words", 64'(sts_words), 64'd8);
        chk("restart_done", 64'(done_cnt), 64'd1);
        if (beats.size() == 8) begin
            chk("restart_beat0", beats[0][63:0], ram_word(16'h0080));
            chk("restart_beat7", beats[7], {1'b1, ram_word(16'h0087)});
        end

`ifdef ULBF_DATA_RD_LOOP_EN
        // Loop mode: exactly 1000 beats accepted, then stop
        clear_log();
        budget = 1000;
        tready_mode = 3;
        cfg_base = 16'h0040; cfg_size = 16'd2; cfg_iter = 16'd1; cfg_loop = 1'b1; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0; cfg_loop = 1'b0;
        for (int c = 0; c < 3000 && beats.size() < 1000; c++) @(negedge ap_clk);
        tick(5);
        chk("loop_busy_running", 64'(sts_busy), 64'd1);
        cfg_stop = 1'b1;
        tick(1);
        cfg_stop = 1'b0;
        chk("loop_words", 64'(sts_words), 64'd1000);
        chk("loop_idle", 64'(sts_busy), 64'd0);
        chk("loop_no_done", 64'(done_cnt), 64'd0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < beats.size(); i++)
                if (beats[i] !== {1'(i % 2), ram_word(16'h0040 + 16'(i % 2))}) bad++;
            chk("loop_beat_pattern", 64'(bad), 64'd0);
        end
`endif

        // Async reset mid-run
        clear_log();
        tready_mode = 0;
        cfg_base = 16'h0500; cfg_size = 16'd16; cfg_iter = 16'd1; cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        tick(5);
        chk("arst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("arst_enb", 64'(enb), 64'd0);
        chk("arst_busy", 64'(sts_busy), 64'd0);
        chk("arst_words", 64'(sts_words), 64'd0);
        chk("arst_addrb", 64'(addrb), 64'd0);
        tick(2);
        ap_rst_n = 1'b1;
        begin
            int n_rd;
            n_rd = addrs.size();
            tick(5);
            chk("arst_no_reads", 64'(addrs.size()), 64'(n_rd));
        end
        chk("arst_idle", 64'(sts_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
